// File: rtl/box_cmd_parser.sv
// UDP box command parser: collects 14-byte packets, validates them and
// updates the per-camera overlay box registers.
module box_cmd_parser #(
    parameter int          H_ACT     = 1280,
    parameter int          V_ACT     = 720,
    parameter logic [65:0] BOX1_INIT = {11'd100, 10'd100, 11'd300, 10'd300, 24'hFF0000},
    parameter logic [65:0] BOX2_INIT = {11'd100, 10'd100, 11'd200, 10'd500, 24'hFF0000}
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic [7:0]  data,
    input  logic [15:0] data_len,
    output logic [10:0] box1_sx,
    output logic [9:0]  box1_sy,
    output logic [10:0] box1_ex,
    output logic [9:0]  box1_ey,
    output logic [23:0] box1_color,
    output logic [10:0] box2_sx,
    output logic [9:0]  box2_sy,
    output logic [10:0] box2_ex,
    output logic [9:0]  box2_ey,
    output logic [23:0] box2_color,
    output logic [1:0]  upd,
    output logic        err,
    output logic [1:0]  err_code
);

    localparam logic [15:0] PKT_LEN = 16'd14;
    localparam logic [7:0]  MAGIC   = 8'hA5;
    localparam logic [16:0] H_LIM   = 17'(H_ACT);
    localparam logic [16:0] V_LIM   = 17'(V_ACT);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        CHECK,
        DRAIN
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nxt;
    logic        wr_en;
    logic        len_err;
    logic        eval;
    logic [7:0]  pkt [0:13];

    logic [15:0] sx;
    logic [15:0] sy;
    logic [15:0] ex;
    logic [15:0] ey;
    logic [23:0] color;
    logic [7:0]  csum;
    logic        hdr_bad;
    logic        sum_bad;
    logic        rng_ok;
    logic        cam;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        wr_en     = 1'b0;
        len_err   = 1'b0;
        eval      = 1'b0;
        unique case (state)
            IDLE: begin
                if (valid) begin
                    wr_en = 1'b1;
                    if (data_len != PKT_LEN) begin
                        state_nxt = DRAIN;
                        len_err   = 1'b1;
                        cnt_nxt   = 4'd0;
                    end else begin
                        state_nxt = RECV;
                        cnt_nxt   = 4'd1;
                    end
                end
            end
            RECV: begin
                if (valid) begin
                    wr_en   = 1'b1;
                    cnt_nxt = cnt + 4'd1;
                    if (cnt == 4'd13) begin
                        state_nxt = CHECK;
                    end
                end else begin
                    state_nxt = IDLE;
                    len_err   = 1'b1;
                    cnt_nxt   = 4'd0;
                end
            end
            CHECK: begin
                cnt_nxt = 4'd0;
                if (valid) begin
                    state_nxt = DRAIN;
                    len_err   = 1'b1;
                end else begin
                    state_nxt = IDLE;
                    eval      = 1'b1;
                end
            end
            DRAIN: begin
                cnt_nxt = 4'd0;
                if (!valid) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Byte store is address-indexed by the running count; no reset needed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            pkt[cnt] <= data;
        end
    end

    always_comb begin
        csum = 8'd0;
        for (int i = 0; i < 13; i++) begin
            csum = csum ^ pkt[i];
        end
    end

    assign sx    = {pkt[2], pkt[3]};
    assign sy    = {pkt[4], pkt[5]};
    assign ex    = {pkt[6], pkt[7]};
    assign ey    = {pkt[8], pkt[9]};
    assign color = {pkt[10], pkt[11], pkt[12]};
    assign cam   = pkt[1][0];

    assign hdr_bad = (pkt[0] != MAGIC) || (pkt[1] > 8'd1);
    assign sum_bad = (csum != pkt[13]);

    // Upper-bit tests keep truncated fields from aliasing into range.
    assign rng_ok = (sx < ex) && ({1'b0, ex} < H_LIM) && (ex[15:11] == 5'd0)
                 && (sy < ey) && ({1'b0, ey} < V_LIM) && (ey[15:10] == 6'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            {box1_sx, box1_sy, box1_ex, box1_ey, box1_color} <= BOX1_INIT;
            {box2_sx, box2_sy, box2_ex, box2_ey, box2_color} <= BOX2_INIT;
            upd      <= 2'b00;
            err      <= 1'b0;
            err_code <= 2'd0;
        end else begin
            upd      <= 2'b00;
            err      <= 1'b0;
            err_code <= 2'd0;
            if (len_err) begin
                err      <= 1'b1;
                err_code <= 2'd0;
            end else if (eval) begin
                if (hdr_bad) begin
                    err      <= 1'b1;
                    err_code <= 2'd1;
                end else if (sum_bad) begin
                    err      <= 1'b1;
                    err_code <= 2'd2;
                end else if (!rng_ok) begin
                    err      <= 1'b1;
                    err_code <= 2'd3;
                end else if (!cam) begin
                    box1_sx    <= sx[10:0];
                    box1_sy    <= sy[9:0];
                    box1_ex    <= ex[10:0];
                    box1_ey    <= ey[9:0];
                    box1_color <= color;
                    upd        <= 2'b01;
                end else begin
                    box2_sx    <= sx[10:0];
                    box2_sy    <= sy[9:0];
                    box2_ex    <= ex[10:0];
                    box2_ey    <= ey[9:0];
                    box2_color <= color;
                    upd        <= 2'b10;
                end
            end
        end
    end

endmodule

// File: tb/tb_box_cmd_parser.sv
// Bench for box_cmd_parser: directed table, corner sequences and
// randomized packets against a packet-level reference model.
module tb_box_cmd_parser;

    localparam int H = 1280;
    localparam int V = 720;
    localparam logic [65:0] I1 = {11'd100, 10'd100, 11'd300, 10'd300, 24'hFF0000};
    localparam logic [65:0] I2 = {11'd100, 10'd100, 11'd200, 10'd500, 24'hFF0000};

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [7:0]  data;
    logic [15:0] data_len;
    logic [10:0] box1_sx, box2_sx, box1_ex, box2_ex;
    logic [9:0]  box1_sy, box2_sy, box1_ey, box2_ey;
    logic [23:0] box1_color, box2_color;
    logic [1:0]  upd;
    logic        err;
    logic [1:0]  err_code;

    box_cmd_parser dut (
        .clk(clk), .rst(rst), .valid(valid), .data(data), .data_len(data_len),
        .box1_sx(box1_sx), .box1_sy(box1_sy), .box1_ex(box1_ex),
        .box1_ey(box1_ey), .box1_color(box1_color),
        .box2_sx(box2_sx), .box2_sy(box2_sy), .box2_ex(box2_ex),
        .box2_ey(box2_ey), .box2_color(box2_color),
        .upd(upd), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    typedef logic [7:0] bq_t[$];

    typedef struct {
        logic [7:0]  b [16];
        int          n;
        logic [15:0] len;
        int          exp;   // 0..3 err code, 4 upd cam0, 5 upd cam1
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          n_upd, n_err, n_both = 0;
    logic [1:0]  last_upd, last_code;
    logic [65:0] m_box1, m_box2;

    task automatic check(input string name, input logic [65:0] got, input logic [65:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        if (upd != 2'b00) begin
            n_upd++;
            last_upd = upd;
        end
        if (err) begin
            n_err++;
            last_code = err_code;
        end
        if (upd != 2'b00 && err) n_both++;
    endtask

    function automatic logic [65:0] dut_box1();
        return {box1_sx, box1_sy, box1_ex, box1_ey, box1_color};
    endfunction

    function automatic logic [65:0] dut_box2();
        return {box2_sx, box2_sy, box2_ex, box2_ey, box2_color};
    endfunction

    task automatic clear_obs();
        n_upd = 0;
        n_err = 0;
        last_upd = 2'b00;
        last_code = 2'd0;
    endtask

    task automatic send(input bq_t q, input logic [15:0] len, input int gap);
        clear_obs();
        foreach (q[i]) begin
            valid = 1'b1;
            data = q[i];
            data_len = len;
            cycle();
        end
        valid = 1'b0;
        data = 8'h00;
        repeat (gap) cycle();
    endtask

    function automatic bq_t mk(input logic [7:0] b0, input logic [7:0] cam,
                               input logic [15:0] sx, input logic [15:0] sy,
                               input logic [15:0] ex, input logic [15:0] ey,
                               input logic [23:0] col, input logic corrupt);
        bq_t q;
        logic [7:0] x;
        x = 8'h00;
        q = {b0, cam, sx[15:8], sx[7:0], sy[15:8], sy[7:0], ex[15:8], ex[7:0],
             ey[15:8], ey[7:0], col[23:16], col[15:8], col[7:0]};
        foreach (q[i]) x = x ^ q[i];
        q.push_back(corrupt ? ~x : x);
        return q;
    endfunction

    function automatic vec_t to_vec(input bq_t q, input logic [15:0] len, input int exp);
        vec_t v;
        foreach (v.b[i]) v.b[i] = 8'h00;
        foreach (q[i]) v.b[i] = q[i];
        v.n = q.size();
        v.len = len;
        v.exp = exp;
        return v;
    endfunction

    // Packet-level reference: decides the outcome from the whole byte list.
    task automatic predict(input bq_t b, input logic [15:0] len, output int exp);
        int sx, sy, ex, ey;
        logic [7:0] x;
        logic [65:0] box;
        if (len != 16'd14 || b.size() != 14) begin
            exp = 0;
        end else begin
            x = 8'h00;
            for (int i = 0; i < 13; i++) x = x ^ b[i];
            sx = {b[2], b[3]};
            sy = {b[4], b[5]};
            ex = {b[6], b[7]};
            ey = {b[8], b[9]};
            if (b[0] != 8'hA5 || b[1] > 8'd1) exp = 1;
            else if (x != b[13]) exp = 2;
            else if (!(sx < ex && ex < H && sy < ey && ey < V)) exp = 3;
            else begin
                box = {11'(sx), 10'(sy), 11'(ex), 10'(ey), b[10], b[11], b[12]};
                if (b[1] == 8'd0) m_box1 = box;
                else m_box2 = box;
                exp = 4 + int'(b[1]);
            end
        end
    endtask

    task automatic verify(input string name, input int exp);
        int obs;
        if (n_upd == 1 && n_err == 0 && last_upd == 2'b01) obs = 4;
        else if (n_upd == 1 && n_err == 0 && last_upd == 2'b10) obs = 5;
        else if (n_err == 1 && n_upd == 0) obs = int'(last_code);
        else obs = 9;
        check({name, " event"}, 66'(obs), 66'(exp));
        check({name, " box1"}, dut_box1(), m_box1);
        check({name, " box2"}, dut_box2(), m_box2);
    endtask

    vec_t tbl [$];

    initial begin
        bq_t q;
        bq_t g;
        int exp;
        int k, n, sx, sy, ex, ey;
        logic [15:0] len;

        rst = 1'b1;
        valid = 1'b0;
        data = 8'h00;
        data_len = 16'd0;
        clear_obs();
        repeat (2) cycle();
        check("reset upd", 66'(upd), 66'd0);
        check("reset err", {63'd0, err, err_code}, 66'd0);
        check("reset box1", dut_box1(), I1);
        check("reset box2", dut_box2(), I2);
        rst = 1'b0;
        m_box1 = I1;
        m_box2 = I2;
        cycle();

        // Latency: B13 at N, nothing at N+1, result at N+2.
        q = mk(8'hA5, 8'h00, 16'd50, 16'd40, 16'd500, 16'd400, 24'h00FF00, 1'b0);
        clear_obs();
        foreach (q[i]) begin
            valid = 1'b1;
            data = q[i];
            data_len = 16'd14;
            cycle();
        end
        valid = 1'b0;
        check("lat n+1 upd", 66'(upd), 66'd0);
        check("lat n+1 box1", dut_box1(), I1);
        cycle();
        check("lat n+2 upd", {63'd0, err, upd}, 66'b001);
        check("lat n+2 box1", dut_box1(),
              {11'd50, 10'd40, 11'd500, 10'd400, 24'h00FF00});
        check("lat n+2 box2", dut_box2(), I2);
        m_box1 = {11'd50, 10'd40, 11'd500, 10'd400, 24'h00FF00};

        tbl.push_back(to_vec(mk(8'hA5, 8'h01, 16'd50, 16'd40, 16'd500, 16'd400, 24'h00FF00, 1'b1), 16'd14, 2));
        tbl.push_back(to_vec(mk(8'hA5, 8'h00, 16'd50, 16'd40, 16'h0500, 16'd400, 24'h00FF00, 1'b0), 16'd14, 3));
        tbl.push_back(to_vec(mk(8'hA5, 8'h00, 16'h0200, 16'd40, 16'h0100, 16'd400, 24'h00FF00, 1'b0), 16'd14, 3));
        tbl.push_back(to_vec(mk(8'h5A, 8'h00, 16'd50, 16'd40, 16'd500, 16'd400, 24'h00FF00, 1'b1), 16'd14, 1));
        tbl.push_back(to_vec(mk(8'hA5, 8'h02, 16'd50, 16'd40, 16'd500, 16'd400, 24'h00FF00, 1'b0), 16'd14, 1));
        q = mk(8'hA5, 8'h00, 16'd1, 16'd2, 16'd3, 16'd4, 24'h111111, 1'b0);
        q = q[0:8];
        tbl.push_back(to_vec(q, 16'd14, 0));
        q = mk(8'hA5, 8'h00, 16'd1, 16'd2, 16'd3, 16'd4, 24'h111111, 1'b0);
        q.push_back(8'h77);
        tbl.push_back(to_vec(q, 16'd14, 0));
        tbl.push_back(to_vec(mk(8'hA5, 8'h00, 16'd7, 16'd8, 16'd9, 16'd10, 24'hABCDEF, 1'b0), 16'd14, 4));
        tbl.push_back(to_vec(mk(8'hA5, 8'h01, 16'd10, 16'd20, 16'd1279, 16'd719, 24'h123456, 1'b0), 16'd14, 5));
        tbl.push_back(to_vec(mk(8'hA5, 8'h01, 16'd1, 16'd2, 16'h0805, 16'd9, 24'h000001, 1'b0), 16'd14, 3));
        tbl.push_back(to_vec(mk(8'hA5, 8'h00, 16'd0, 16'd2, 16'd5, 16'd720, 24'h000002, 1'b0), 16'd14, 3));
        tbl.push_back(to_vec(mk(8'hA5, 8'h01, 16'd5, 16'd2, 16'd5, 16'd9, 24'h000003, 1'b0), 16'd14, 3));
        tbl.push_back(to_vec(mk(8'hA5, 8'h00, 16'd1, 16'd2, 16'd3, 16'd4, 24'h000004, 1'b0), 16'd13, 0));
        tbl.push_back(to_vec(mk(8'hA5, 8'h00, 16'd0, 16'd0, 16'd1, 16'd1, 24'hFFFFFF, 1'b0), 16'd14, 4));

        foreach (tbl[t]) begin
            q = {};
            for (int i = 0; i < tbl[t].n; i++) q.push_back(tbl[t].b[i]);
            send(q, tbl[t].len, 1);
            predict(q, tbl[t].len, exp);
            verify($sformatf("tbl%0d", t), tbl[t].exp);
        end

        // Reset in the middle of a packet: nothing from it may surface.
        q = mk(8'hA5, 8'h00, 16'd60, 16'd61, 16'd62, 16'd63, 24'h0A0B0C, 1'b0);
        clear_obs();
        for (int i = 0; i < 6; i++) begin
            valid = 1'b1;
            data = q[i];
            data_len = 16'd14;
            cycle();
        end
        rst = 1'b1;
        data = q[6];
        cycle();
        rst = 1'b0;
        valid = 1'b0;
        repeat (3) cycle();
        m_box1 = I1;
        m_box2 = I2;
        check("midrst pulses", 66'(n_upd + n_err), 66'd0);
        check("midrst box1", dut_box1(), I1);
        check("midrst box2", dut_box2(), I2);

        // Bytes after reset falls within one valid run start a new packet.
        g = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        foreach (g[i]) begin
            valid = 1'b1;
            data = g[i];
            data_len = 16'd14;
            cycle();
        end
        rst = 1'b1;
        data = 8'h66;
        cycle();
        rst = 1'b0;
        q = mk(8'hA5, 8'h01, 16'd300, 16'd200, 16'd900, 16'd600, 24'h5A5A5A, 1'b0);
        send(q, 16'd14, 1);
        predict(q, 16'd14, exp);
        verify("rst_restart", 5);

        for (int r = 0; r < 80; r++) begin
            k = $urandom_range(0, 7);
            sx = $urandom_range(0, H - 2);
            ex = $urandom_range(sx + 1, H - 1);
            sy = $urandom_range(0, V - 2);
            ey = $urandom_range(sy + 1, V - 1);
            if (k == 5) begin
                sx = $urandom_range(0, 65535);
                ex = $urandom_range(0, 65535);
                sy = $urandom_range(0, 2047);
                ey = $urandom_range(0, 2047);
            end
            q = mk((k == 4) ? 8'($urandom_range(0, 255)) : 8'hA5,
                   (k == 4) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 1)),
                   16'(sx), 16'(sy), 16'(ex), 16'(ey), 24'($urandom), k == 3);
            if (k == 6) begin
                n = $urandom_range(1, 13);
                while (q.size() > n) void'(q.pop_back());
            end
            if (k == 7) begin
                n = $urandom_range(1, 3);
                repeat (n) q.push_back(8'($urandom));
            end
            len = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(0, 20)) : 16'd14;
            send(q, len, $urandom_range(1, 3));
            predict(q, len, exp);
            verify($sformatf("rnd%0d", r), exp);
        end

        check("upd_err_overlap", 66'(n_both), 66'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/box_cmd_parser.md
BOX_CMD_PARSER -- requirements
Module: box_cmd_parser

Interface
REQ-001 SHALL have parameter H_ACT, default 1280, active pixels per line; the exclusive bound for end_x.
REQ-002 SHALL have parameter V_ACT, default 720, active lines per frame; the exclusive bound for end_y.
REQ-003 SHALL have parameter BOX1_INIT, default {11'd100,10'd100,11'd300,10'd300,24'hFF0000}, camera-1 box {sx,sy,ex,ey,color} after reset.
REQ-004 SHALL have parameter BOX2_INIT, default {11'd100,10'd100,11'd200,10'd500,24'hFF0000}, camera-2 box after reset.
REQ-005 SHALL have port clk  in  1, the UDP receive clock; one clock only, all logic on the rising edge.
REQ-006 SHALL have port rst  in  1, synchronous, active-high reset.
REQ-007 SHALL have port valid  in  1, high for one clock per received payload byte; a packet is a contiguous run of valid-high cycles.
REQ-008 SHALL have port data  in  8, the payload byte, qualified by valid.
REQ-009 SHALL have port data_len  in  16, the payload length, sampled on the first valid cycle of a packet.
REQ-010 SHALL have ports box1_sx/box2_sx  out  11, box1_sy/box2_sy  out  10, box1_ex/box2_ex  out  11, box1_ey/box2_ey  out  10, and box1_color/box2_color  out  24, the registered box per camera.
REQ-011 SHALL have port upd  out  2, a one-cycle pulse; bit0 = camera 1 box updated, bit1 = camera 2 box updated.
REQ-012 SHALL have port err  out  1, a one-cycle pulse when a packet is rejected.
REQ-013 SHALL have port err_code  out  2, the rejection cause, valid while err=1: 0 length, 1 header, 2 checksum, 3 range.

Function
REQ-014 Packet format SHALL be 14 bytes, multi-byte fields big-endian:
  - B0 = magic 0xA5; B1 = cam_id (0x00 or 0x01).
  - B2-3 = sx; B4-5 = sy; B6-7 = ex; B8-9 = ey.
  - B10-12 = R,G,B.
  - B13 = XOR of B0..B12.
REQ-015 The FSM SHALL have states IDLE, RECV, CHECK, DRAIN; reset state IDLE.
REQ-016 IDLE: valid=1 captures the byte as B0 and samples data_len.
  - data_len != 14 -> DRAIN, err/code 0 pulse on the next cycle.
  - Otherwise -> RECV with byte count 1.
REQ-017 RECV: each valid=1 stores the byte at the current count and increments the count.
  - valid=0 with count < 14 -> IDLE, err/code 0 pulse on the next cycle, no output change.
  - After byte 13 is accepted -> CHECK.
REQ-018 CHECK (the cycle after B13):
  - valid=1 (over-length) -> DRAIN, err/code 0 on the next cycle.
  - valid=0 -> evaluate the packet and return to IDLE.
REQ-019 DRAIN SHALL ignore bytes until valid samples 0, then -> IDLE; no further err pulses for that packet.
REQ-020 Evaluation priority SHALL be header (B0 != 0xA5 or B1 > 1) > checksum mismatch > range; only the highest-priority failure is reported.
REQ-021 Range check SHALL pass only if sx < ex < H_ACT and sy < ey < V_ACT.
  - Compare sx/ex as the full 16-bit fields before truncation to 11 bits; sy/ey likewise before truncation to 10 bits.
  - Any nonzero bits above the output width fail the check.
REQ-022 On a pass, the selected camera's five outputs SHALL update in the cycle after CHECK, with upd[cam_id]=1 in that same cycle; the other camera's outputs are unchanged.
REQ-023 Latency SHALL be: B13 accepted at cycle N -> outputs and upd visible at N+2; a rejected packet's err is visible at N+2.
REQ-024 A new packet MAY start on the cycle after CHECK (valid low for exactly one cycle between packets) and SHALL be accepted.
REQ-025 Box outputs SHALL never change except as in REQ-022 or on reset; all five fields of a box change in the same cycle.
REQ-026 upd and err SHALL never be high in the same cycle.

Reset
REQ-027 rst=1 SHALL, on the next edge: state=IDLE, byte count=0, upd=0, err=0, err_code=0, box1_* = BOX1_INIT, box2_* = BOX2_INIT.
REQ-028 rst asserted mid-packet SHALL discard the partial packet; bytes arriving after rst falls while valid is still high SHALL be treated as a new packet.

Verification
REQ-029 Valid packet A5 00 0032 0028 01F4 0190 00FF00 + checksum -> at N+2: upd=01, box1 = (50,40,500,400,00FF00), box2 unchanged.
REQ-030 Same packet with cam_id 01 and a corrupted B13 -> err=1, code 2, upd=00, both boxes unchanged.
REQ-031 ex=0x0500 (1280), valid checksum -> err code 3; sx=0x0200, ex=0x0100 -> err code 3; B0=0x5A -> err code 1, even if the checksum is also wrong.
REQ-032 valid drops after 9 bytes -> err code 0 once, FSM back in IDLE; a 15-byte burst -> exactly one err code 0 and no update.
REQ-033 Two valid packets for cam 0 then cam 1, separated by one idle cycle -> two upd pulses (01, then 10) with both boxes correct.
REQ-034 rst pulsed at byte 6 of a packet -> boxes = INIT values, no upd/err from the discarded packet.
